// File: rtl/fp32_vec_gather_pkg.sv
// Shared types for the FP32_8 vector gather block.
// Optional feature macro: FP_GATHER_SPECIAL_FLAG_EN (per-lane Inf/NaN flag).
package fp32_vec_gather_pkg;

  localparam int unsigned EXP_WIDTH  = 8;
  localparam int unsigned MANT_WIDTH = 23;
  localparam int unsigned FP_WIDTH   = 1 + EXP_WIDTH + MANT_WIDTH;

  typedef struct packed {
    logic                  sign;
    logic [EXP_WIDTH-1:0]  exp;
    logic [MANT_WIDTH-1:0] mant;
  } fp32_8_t;

  // True for Inf and NaN encodings (exponent all ones).
  function automatic logic is_inf_nan(input fp32_8_t v);
    return &v.exp;
  endfunction

endpackage

// File: rtl/fp32_gather_bank.sv
// One bank of the ping-pong gather buffer: LENGTH lane registers, element
// count, full flag and zero masking of lanes beyond the count.
// Optional feature macro: FP_GATHER_SPECIAL_FLAG_EN (per-lane Inf/NaN flag).
module fp32_gather_bank
  import fp32_vec_gather_pkg::*;
#(
  parameter  int unsigned LENGTH = 8,
  localparam int unsigned CNT_W  = $clog2(LENGTH + 1),
  localparam int unsigned IDX_W  = $clog2(LENGTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [FP_WIDTH-1:0]    wr_data,
  input  logic                   close,
  input  logic                   drain,
  output logic                   full,
  output logic [CNT_W-1:0]       cnt,
  output logic [LENGTH*32-1:0]   data
`ifdef FP_GATHER_SPECIAL_FLAG_EN
  ,
  output logic [LENGTH-1:0]      special
`endif
);

  fp32_8_t          lane_q [LENGTH];
  fp32_8_t          lane_d [LENGTH];
  logic             full_q, full_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef FP_GATHER_SPECIAL_FLAG_EN
  logic [LENGTH-1:0] spec_q, spec_d;
`endif

  // Next state: lane write, close (set full, latch count) and drain (clear full).
  always_comb begin
    lane_d = lane_q;
    full_d = full_q;
    cnt_d  = cnt_q;
`ifdef FP_GATHER_SPECIAL_FLAG_EN
    spec_d = spec_q;
`endif
    if (wr_en) begin
      lane_d[wr_idx] = fp32_8_t'(wr_data);
`ifdef FP_GATHER_SPECIAL_FLAG_EN
      spec_d[wr_idx] = is_inf_nan(fp32_8_t'(wr_data));
`endif
    end
    if (close) begin
      full_d = 1'b1;
      cnt_d  = CNT_W'(wr_idx) + CNT_W'(1);
    end
    if (drain) begin
      full_d = 1'b0;
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 1'b0;
      cnt_q  <= '0;
`ifdef FP_GATHER_SPECIAL_FLAG_EN
      spec_q <= '0;
`endif
    end else begin
      full_q <= full_d;
      cnt_q  <= cnt_d;
`ifdef FP_GATHER_SPECIAL_FLAG_EN
      spec_q <= spec_d;
`endif
    end
  end

  // Lane payload; stale contents are hidden by the count mask, so no reset.
  always_ff @(posedge clk) begin
    lane_q <= lane_d;
  end

  // Present populated lanes, force unpopulated lanes to +0.0.
  always_comb begin
    data = '0;
`ifdef FP_GATHER_SPECIAL_FLAG_EN
    special = '0;
`endif
    for (int unsigned i = 0; i < LENGTH; i++) begin
      if (CNT_W'(i) < cnt_q) begin
        data[i*32 +: 32] = lane_q[i];
`ifdef FP_GATHER_SPECIAL_FLAG_EN
        special[i] = spec_q[i];
`endif
      end
    end
    full = full_q;
    cnt  = cnt_q;
  end

endmodule

// File: rtl/fp32_vec_gather.sv
// Scalar FP32_8 stream to FP32_8[LENGTH] vector packer with a ping-pong
// double buffer, sustaining one element per cycle; in_last closes short vectors.
// Optional feature macro: FP_GATHER_SPECIAL_FLAG_EN adds out_special.
module fp32_vec_gather
  import fp32_vec_gather_pkg::*;
#(
  parameter  int unsigned LENGTH = 8,
  localparam int unsigned CNT_W  = $clog2(LENGTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [LENGTH*32-1:0] out_data,
  output logic [CNT_W-1:0]     out_count,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 debugen_in
`ifdef FP_GATHER_SPECIAL_FLAG_EN
  ,
  output logic [LENGTH-1:0]    out_special
`endif
);

  localparam int unsigned IDX_W = $clog2(LENGTH);

  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;

  logic [1:0]            full;
  logic [CNT_W-1:0]      cnt  [2];
  logic [LENGTH*32-1:0]  data [2];
`ifdef FP_GATHER_SPECIAL_FLAG_EN
  logic [LENGTH-1:0]     special [2];
`endif

  logic       accept, close, drain;
  logic [1:0] bank_wr, bank_close, bank_drain;

  // Trace port kept for interface compatibility; tracing is not synthesized.
  logic unused_debugen;
  assign unused_debugen = debugen_in;

  // Handshake, per-bank strobes, output mux and pointer next state.
  always_comb begin
    in_ready   = !full[wr_bank_q];
    accept     = in_valid && in_ready;
    close      = accept && (in_last || (wr_idx_q == IDX_W'(LENGTH - 1)));
    out_valid  = full[rd_bank_q];
    drain      = out_valid && out_ready;
    bank_wr    = '0;
    bank_close = '0;
    bank_drain = '0;
    bank_wr[wr_bank_q]    = accept;
    bank_close[wr_bank_q] = close;
    bank_drain[rd_bank_q] = drain;
    out_count  = cnt[rd_bank_q];
    out_data   = data[rd_bank_q];
`ifdef FP_GATHER_SPECIAL_FLAG_EN
    out_special = special[rd_bank_q];
`endif
    wr_bank_d = wr_bank_q ^ close;
    rd_bank_d = rd_bank_q ^ drain;
    wr_idx_d  = wr_idx_q;
    if (close) begin
      wr_idx_d = '0;
    end else if (accept) begin
      wr_idx_d = wr_idx_q + IDX_W'(1);
    end
  end

  // Write/read bank pointers and write lane index.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= '0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fp32_gather_bank #(
      .LENGTH(LENGTH)
    ) u_bank (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (bank_wr[b]),
      .wr_idx  (wr_idx_q),
      .wr_data (in_data),
      .close   (bank_close[b]),
      .drain   (bank_drain[b]),
      .full    (full[b]),
      .cnt     (cnt[b]),
      .data    (data[b])
`ifdef FP_GATHER_SPECIAL_FLAG_EN
      ,
      .special (special[b])
`endif
    );
  end

endmodule

// File: tb/tb_fp32_vec_gather.sv
// Self-checking bench for fp32_vec_gather (LENGTH=8): a queue-based
// reference model of closed vectors plus directed literal checks.
`timescale 1ns/1ps
module tb_fp32_vec_gather;

  localparam int unsigned L  = 8;
  localparam int unsigned CW = $clog2(L + 1);

  logic            clk = 1'b0;
  logic            reset;
  logic [31:0]     in_data;
  logic            in_valid;
  logic            in_last;
  logic            in_ready;
  logic [L*32-1:0] out_data;
  logic [CW-1:0]   out_count;
  logic            out_valid;
  logic            out_ready;
  logic            debugen_in;
`ifdef FP_GATHER_SPECIAL_FLAG_EN
  logic [L-1:0]    out_special;
`endif

  fp32_vec_gather #(.LENGTH(L)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_count  (out_count),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .debugen_in (debugen_in)
`ifdef FP_GATHER_SPECIAL_FLAG_EN
    ,
    .out_special(out_special)
`endif
  );

  always #5 clk = ~clk;

  // Reference: a vector is a count plus lanes (zero beyond the count).
  typedef struct packed {
    logic [31:0]         cnt;
    logic [L-1:0][31:0]  lane;
  } vec_t;

  vec_t        exp_q[$];
  logic [31:0] part[$];
  vec_t        mv;
  logic        pend_full;
  bit          live = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          acc_cnt = 0;
  int          stall_cnt = 0;
  bit          rnd_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model update: at most two closed vectors may be pending; a drain and an
  // accept in the same cycle both happen, acceptance judged on the old state.
  initial forever begin
    @(posedge clk);
    if (reset) begin
      exp_q.delete();
      part.delete();
      live = 1;
    end else if (live) begin
      pend_full = (exp_q.size() >= 2);
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (in_valid && !pend_full) begin
        part.push_back(in_data);
        if (in_last || part.size() == L) begin
          mv = '0;
          mv.cnt = part.size();
          for (int i = 0; i < part.size(); i++) mv.lane[i] = part[i];
          exp_q.push_back(mv);
          part.delete();
        end
      end
    end
  end

  // Compare every cycle, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (live) begin
      chk("in_ready", in_ready, exp_q.size() < 2);
      chk("out_valid", out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        chk("out_count", out_count, exp_q[0].cnt);
        for (int i = 0; i < L; i++)
          chk($sformatf("lane%0d", i), out_data[i*32 +: 32], exp_q[0].lane[i]);
`ifdef FP_GATHER_SPECIAL_FLAG_EN
        for (int i = 0; i < L; i++)
          chk($sformatf("special%0d", i), out_special[i], &exp_q[0].lane[i][30:23]);
`endif
      end
    end
  end

  // Offer one element and hold it until accepted (bounded).
  task automatic send(input logic [31:0] d, input logic last);
    bit acc = 0;
    int waits = 0;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (!acc) begin
        stall_cnt++;
        waits++;
        if (waits > 200) begin
          chk("send_timeout", 1, 0);
          finish_run();
        end
      end
    end
    acc_cnt++;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    #5_000_000;
    chk("watchdog", 1, 0);
    finish_run();
  end

  initial begin
    logic [31:0] d;
    int g;
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    out_ready = 1'b0; debugen_in = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_data", |out_data, 0);

    // 1: full vector, visible one cycle after the 8th element.
    step();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) send(32'h3F80_0000 + k, 1'b0);
    @(negedge clk);
    chk("t1_valid", out_valid, 1);
    chk("t1_count", out_count, 8);
    for (int k = 0; k < 8; k++) chk("t1_lane", out_data[k*32 +: 32], 32'h3F80_0000 + k);
    step();
    stall_cnt = 0;
    for (int k = 0; k < 16; k++) send(32'h3F80_0010 + k, 1'b0);
    chk("t1_no_stall", stall_cnt, 0);
    repeat (4) step();

    // 2: short vector closed by in_last.
    for (int k = 0; k < 3; k++) send(32'h4040_0000 + k, k == 2);
    @(negedge clk);
    chk("t2_count", out_count, 3);
    for (int k = 0; k < 3; k++) chk("t2_lane", out_data[k*32 +: 32], 32'h4040_0000 + k);
    for (int k = 3; k < 8; k++) chk("t2_zero", out_data[k*32 +: 32], 0);
    repeat (2) step();

    // 3: backpressure, both banks fill, single drain reopens a bank.
    out_ready = 1'b0;
    acc_cnt = 0;
    fork
      begin
        for (int k = 0; k < 20; k++) send(32'h4100_0000 + k, k == 19);
      end
      begin
        g = 0;
        while (acc_cnt < 16 && g < 100) begin @(negedge clk); g++; end
        @(negedge clk);
        chk("t3_stall", in_ready, 0);
        repeat (3) @(negedge clk);
        chk("t3_held16", acc_cnt, 16);
        chk("t3_v1_lane0", out_data[31:0], 32'h4100_0000);
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        @(negedge clk);
        chk("t3_reopen", in_ready, 1);
      end
    join
    @(negedge clk);
    chk("t3_v2_lane0", out_data[31:0], 32'h4100_0008);
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    @(negedge clk);
    chk("t3_v3_count", out_count, 4);
    chk("t3_v3_lane0", out_data[31:0], 32'h4100_0010);
    chk("t3_v3_lane3", out_data[127:96], 32'h4100_0013);
    chk("t3_v3_lane4", out_data[159:128], 0);
    step();
    out_ready = 1'b1;
    repeat (3) step();

    // 4: reset with a presented vector and a partial one.
    out_ready = 1'b0;
    for (int k = 0; k < 13; k++) send(32'h4200_0000 + k, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("t4_valid", out_valid, 0);
    chk("t4_ready", in_ready, 1);
    step();
    for (int k = 0; k < 8; k++) send(32'h4300_0000 + k, 1'b0);
    @(negedge clk);
    chk("t4_count", out_count, 8);
    chk("t4_lane0", out_data[31:0], 32'h4300_0000);
    step();
    out_ready = 1'b1;
    repeat (3) step();

    // 5: random traffic against the model.
    rnd_done = 0;
    fork
      begin
        for (int n = 0; n < 10000; n++) begin
          if ($urandom_range(0, 3) == 0) step();
          d = $urandom;
          if ($urandom_range(0, 7) == 0) d[30:23] = 8'hFF;
          send(d, $urandom_range(0, 5) == 0);
        end
        send(32'h0BAD_F00D, 1'b1);
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          step();
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    g = 0;
    while (exp_q.size() != 0 && g < 50) begin step(); g++; end
    chk("t5_drained", exp_q.size(), 0);
    @(negedge clk);
    chk("t5_idle_valid", out_valid, 0);

`ifdef FP_GATHER_SPECIAL_FLAG_EN
    // 6: Inf and NaN lanes flagged, finite lane not.
    step();
    out_ready = 1'b0;
    send(32'h7F80_0000, 1'b0);
    send(32'h7FC0_0000, 1'b0);
    send(32'h3F80_0000, 1'b1);
    @(negedge clk);
    chk("t6_count", out_count, 3);
    chk("t6_special", out_special, 8'b0000_0011);
    step();
    out_ready = 1'b1;
    repeat (3) step();
`endif

    finish_run();
  end

endmodule
